dual_rail_responder: RTL and testbench

- Clocked responder at the resource end of the dual-rail bus.
- Receives a two-phase (LEDR) dual-rail token on `in` from the bus arbiter and decodes it to binary.
- Hands the decoded word to a synchronous core over a valid/ready request channel.
- Takes the core's result over a valid/ready response channel, encodes it as the next LEDR token on `out`, and only then accepts the next input token.

---
 rtl/dual_rail_responder_if.sv | 44 ++++
 rtl/dual_rail_responder.sv | 158 +++++++++++++++
 tb/tb_dual_rail_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dual_rail_responder_if.sv
// Bundles the responder's LEDR token rails and the core request/response channels.
// Latency: none, signal grouping only.
// Backpressure: req_ready throttles requests, rsp_ready gates results; the bus waits for out.
interface dual_rail_responder_if #(
    parameter int INPUT  = 4,
    parameter int OUTPUT = 4
) ();
    // Each Dual element is {v, r}: bit [1] is the value rail, bit [0] the reference rail
    logic [INPUT-1:0][1:0]  in;
    logic [OUTPUT-1:0][1:0] out;
    logic                   req_valid;
    logic                   req_ready;
    logic [INPUT-1:0]       req_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [OUTPUT-1:0]      rsp_data;
    logic                   busy;

    // Responder side
    modport slave (
        input  in,
        output out,
        output req_valid,
        input  req_ready,
        output req_data,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        output busy
    );

    // Bus arbiter plus synchronous core side
    modport master (
        output in,
        input  out,
        input  req_valid,
        output req_ready,
        input  req_data,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        input  busy
    );
endinterface

// File: rtl/dual_rail_responder.sv
// Decodes an LEDR dual-rail token to a core request and encodes the core result as the next LEDR token.
// Latency: last rail change to req_valid = SYNC_STAGES + STABLE cycles; response handshake to out = 1 cycle.
// Backpressure: req_valid/req_data held until req_ready; rsp_ready only in WAIT_RESULT; input ignored while busy.
module dual_rail_responder #(
    parameter int INPUT       = 4,
    parameter int OUTPUT      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dual_rail_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_RESULT = 2'd2,
        EMIT        = 2'd3
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;

    logic [SYNC_STAGES-1:0][INPUT-1:0][1:0] r_sync;
    logic [INPUT-1:0][1:0]                  w_word;
    logic [INPUT-1:0]                       w_val;
    logic [INPUT-1:0]                       w_phase;
    logic                                   w_complete;

    logic [INPUT-1:0]                       r_prev;
    logic [2:0]                             r_cnt;
    logic [2:0]                             w_cnt_nxt;

    logic                                   w_accept;
    logic                                   w_req_hs;
    logic                                   w_rsp_hs;

    logic                                   r_ph_in;
    logic                                   r_ph_out;
    logic                                   r_req_valid;
    logic                                   r_rsp_ready;
    logic [INPUT-1:0]                       r_req_data;
    logic [OUTPUT-1:0][1:0]                 r_out;

    // Both rails of every element run through a plain flop chain; the last stage is the sampled word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in};
        end
    end

    assign w_word = r_sync[SYNC_STAGES-1];

    // Split the synchronized word into per-element value and phase, and test for a complete new token
    always_comb begin
        w_val   = '0;
        w_phase = '0;
        for (int i = 0; i < INPUT; i++) begin
            w_val[i]   = w_word[i][1];
            w_phase[i] = w_word[i][1] ^ w_word[i][0];
        end
        w_complete = (w_phase == {INPUT{~r_ph_in}});
    end

    // Stability count: mixed phases clear it, a changed value restarts it at 1, a repeat extends it
    always_comb begin
        w_cnt_nxt = 3'd0;
        if (w_complete) begin
            if ((r_cnt != 3'd0) && (w_val == r_prev)) begin
                w_cnt_nxt = r_cnt + 3'd1;
            end else begin
                w_cnt_nxt = 3'd1;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_complete && (w_cnt_nxt == 3'(STABLE));
    assign w_req_hs = r_req_valid && bus.req_ready;
    assign w_rsp_hs = bus.rsp_valid && r_rsp_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept token, hand to core, wait for result, one emit cycle before re-arming
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:        if (w_accept) w_state_nxt = ISSUE;
            ISSUE:       if (w_req_hs) w_state_nxt = WAIT_RESULT;
            WAIT_RESULT: if (w_rsp_hs) w_state_nxt = EMIT;
            EMIT:        w_state_nxt = IDLE;
            default:     w_state_nxt = IDLE;
        endcase
    end

    // Stability tracking only advances in IDLE, so leaving EMIT always starts from a cleared count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 3'd0;
            r_prev <= '0;
        end else if (r_state == IDLE && !w_accept) begin
            r_cnt  <= w_cnt_nxt;
            r_prev <= w_val;
        end else begin
            r_cnt  <= 3'd0;
        end
    end

    // Request channel: latch the decoded word and flip the input reference phase on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_data  <= '0;
            r_ph_in     <= 1'b0;
            r_rsp_ready <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_valid <= 1'b1;
                r_req_data  <= w_val;
                r_ph_in     <= ~r_ph_in;
            end else if (w_req_hs) begin
                r_req_valid <= 1'b0;
                r_rsp_ready <= 1'b1;
            end else if (w_rsp_hs) begin
                r_rsp_ready <= 1'b0;
            end
        end
    end

    // Result token: v = data, r = data ^ new phase, so each element moves exactly one rail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out    <= '0;
            r_ph_out <= 1'b0;
        end else if (w_rsp_hs) begin
            for (int i = 0; i < OUTPUT; i++) begin
                r_out[i] <= {bus.rsp_data[i], bus.rsp_data[i] ^ ~r_ph_out};
            end
            r_ph_out <= ~r_ph_out;
        end
    end

    assign bus.out       = r_out;
    assign bus.req_valid = r_req_valid;
    assign bus.req_data  = r_req_data;
    assign bus.rsp_ready = r_rsp_ready;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dual_rail_responder.sv
// Randomized bench for dual_rail_responder against a token-level reference model.
// Latency: checks the SYNC_STAGES + STABLE acceptance window and 1-cycle result emission.
// Backpressure: exercises held req_ready with input glitches, delayed responses and mid-flight reset.
module tb_dual_rail_responder;

    localparam int N = 4;
    localparam int S = 2;
    localparam int T = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dual_rail_responder_if #(.INPUT(N), .OUTPUT(N)) bus ();

    dual_rail_responder #(
        .INPUT(N), .OUTPUT(N), .SYNC_STAGES(S), .STABLE(T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bus-level phases and the token currently on out
    logic           m_ph_in;
    logic           m_ph_out;
    logic [2*N-1:0] m_out;
    logic [2*N-1:0] cur_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // LEDR encoding: element i is {v, r} with v = d[i], r = d[i] ^ phase
    function automatic logic [2*N-1:0] enc(input logic [N-1:0] d, input logic p);
        logic [2*N-1:0] res;
        for (int i = 0; i < N; i++) begin
            res[2*i+1] = d[i];
            res[2*i]   = d[i] ^ p;
        end
        return res;
    endfunction

    function automatic logic one_rail(input logic [2*N-1:0] a, input logic [2*N-1:0] b);
        logic [1:0] d;
        for (int i = 0; i < N; i++) begin
            d = a[2*i +: 2] ^ b[2*i +: 2];
            if (d != 2'b01 && d != 2'b10) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        cur_in        = '0;
        bus.in        = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        tick();
        tick();
        chk("rst_out", bus.out, '0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_rsp_ready", bus.rsp_ready, 0);
        chk("rst_req_data", bus.req_data, '0);
        m_ph_in  = 1'b0;
        m_ph_out = 1'b0;
        m_out    = '0;
        reset    = 1'b0;
        tick();
    endtask

    // Present a word already at the accepted phase; it must never raise req_valid
    task automatic rep_phase(input logic [N-1:0] val);
        cur_in = enc(val, m_ph_in);
        bus.in = cur_in;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("repeat_no_valid", bus.req_valid, 0);
        end
    endtask

    task automatic do_txn(input logic [N-1:0] val, input bit skew, input int hold, input bit glitch,
                          input logic [N-1:0] rdat, input int rsp_wait, input bit rst_in_wait);
        logic           p;
        logic [2*N-1:0] tgt;
        logic [2*N-1:0] old_out;
        int             ord[N];
        int             lat;
        bit             got;
        int             j;
        int             tmp;

        p   = ~m_ph_in;
        tgt = enc(val, p);
        chk("idle_busy", bus.busy, 0);
        chk("idle_req_valid", bus.req_valid, 0);

        if (skew) begin
            for (int i = 0; i < N; i++) ord[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j      = $urandom_range(i, 0);
                tmp    = ord[i];
                ord[i] = ord[j];
                ord[j] = tmp;
            end
            for (int k = 0; k < N; k++) begin
                cur_in[2*ord[k] +: 2] = tgt[2*ord[k] +: 2];
                bus.in = cur_in;
                if (k < N - 1) begin
                    tick();
                    chk("skew_no_valid", bus.req_valid, 0);
                end
            end
        end else begin
            cur_in = tgt;
            bus.in = cur_in;
        end

        lat = 0;
        got = 1'b0;
        while (lat < 20 && !got) begin
            tick();
            lat++;
            if (bus.req_valid) got = 1'b1;
        end
        chk("req_valid_seen", got, 1);
        if (!got) begin
            do_reset();
            return;
        end
        chk("latency_window", (lat >= S + T - 1) && (lat <= S + T + 1), 1);
        chk("req_data", bus.req_data, val);
        chk("busy_issue", bus.busy, 1);
        chk("rsp_ready_issue", bus.rsp_ready, 0);
        m_ph_in = p;

        for (int c = 0; c < hold; c++) begin
            if (glitch && c == 1) bus.in = cur_in ^ (2*N)'($urandom_range(255, 1));
            if (glitch && c == 3) bus.in = cur_in;
            tick();
            chk("hold_req_data", bus.req_data, val);
            chk("hold_req_valid", bus.req_valid, 1);
            chk("hold_rsp_ready", bus.rsp_ready, 0);
        end
        bus.in = cur_in;

        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        chk("req_valid_drop", bus.req_valid, 0);
        chk("rsp_ready_wait", bus.rsp_ready, 1);
        chk("busy_wait", bus.busy, 1);

        for (int c = 0; c < rsp_wait; c++) begin
            tick();
            chk("wait_out_hold", bus.out, m_out);
            chk("wait_rsp_ready", bus.rsp_ready, 1);
        end

        if (rst_in_wait) begin
            @(negedge clk);
            reset  = 1'b1;
            cur_in = '0;
            bus.in = '0;
            #1;
            chk("arst_out", bus.out, '0);
            chk("arst_busy", bus.busy, 0);
            chk("arst_req_valid", bus.req_valid, 0);
            chk("arst_rsp_ready", bus.rsp_ready, 0);
            chk("arst_req_data", bus.req_data, '0);
            m_ph_in  = 1'b0;
            m_ph_out = 1'b0;
            m_out    = '0;
            @(negedge clk);
            reset = 1'b0;
            tick();
            return;
        end

        old_out       = bus.out;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rdat;
        tick();
        bus.rsp_valid = 1'b0;
        m_out    = enc(rdat, ~m_ph_out);
        m_ph_out = ~m_ph_out;
        chk("out_token", bus.out, m_out);
        chk("one_rail_per_elem", one_rail(old_out, bus.out), 1);
        chk("rsp_ready_drop", bus.rsp_ready, 0);
        chk("busy_emit", bus.busy, 1);
        tick();
        chk("busy_drop", bus.busy, 0);
        chk("out_stable_idle", bus.out, m_out);
    endtask

    initial begin
        bus.in        = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        cur_in        = '0;
        do_reset();

        // Phase-1 token 1111, result 0110 lands as v=0110 r=1001
        do_txn(4'b1111, 1'b0, 0, 1'b0, 4'b0110, 0, 1'b0);
        // Skewed phase-0 token 1010 under backpressure with a glitch; result 0001 at phase 0
        do_txn(4'b1010, 1'b1, 10, 1'b1, 4'b0001, 1, 1'b0);
        chk("phase0_token", m_out, 8'b00_00_00_11);
        rep_phase(4'b0101);
        // Reset while waiting for the result, then a fresh phase-1 token
        do_txn(4'b0011, 1'b0, 2, 1'b0, 4'b1100, 1, 1'b1);
        do_txn(4'b1001, 1'b0, 1, 1'b0, 4'b0111, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(5, 0) == 0) rep_phase(N'($urandom));
            do_txn(N'($urandom), 1'($urandom), $urandom_range(10, 0), 1'($urandom),
                   N'($urandom), $urandom_range(3, 0), ($urandom_range(7, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
